// File: rtl/qpu_exu_qiu_evtq_if.sv
// Instruction and event channels of the QPU timing-point event queue.
// The unit sits on the slave side; the issue stage / timing queue on the master side.
interface qpu_exu_qiu_evtq_if #(
  parameter int QUBIT_NUM = 8,
  parameter int EVT_W     = 7,
  parameter int TIME_W    = 24,
  parameter int IMM_W     = 32,
  parameter int DEPTH     = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                           i_valid;
  logic                           i_ready;
  logic [QUBIT_NUM-1:0]           i_rs1;
  logic [QUBIT_NUM-1:0]           i_rs2;
  logic [EVT_W-1:0]               i_op1;
  logic [EVT_W-1:0]               i_op2;
  logic [IMM_W-1:0]               i_imm;
  logic                           i_measure;
  logic                           i_ntp;
  logic                           i_tsync;
  logic [TIME_W-1:0]              i_tbase;
  logic                           o_valid;
  logic                           o_ready;
  logic [QUBIT_NUM:0]             o_oprand;
  logic [QUBIT_NUM*EVT_W+QUBIT_NUM-1:0] o_edata;
  logic [TIME_W-1:0]              o_tdata;
  logic                           o_ovf;
  logic                           i_ovf_clr;
  logic [CNT_W-1:0]               o_count;

  modport slave (
    input  i_valid, i_rs1, i_rs2, i_op1, i_op2, i_imm, i_measure, i_ntp,
           i_tsync, i_tbase, o_ready, i_ovf_clr,
    output i_ready, o_valid, o_oprand, o_edata, o_tdata, o_ovf, o_count
  );

  modport master (
    output i_valid, i_rs1, i_rs2, i_op1, i_op2, i_imm, i_measure, i_ntp,
           i_tsync, i_tbase, o_ready, i_ovf_clr,
    input  i_ready, o_valid, o_oprand, o_edata, o_tdata, o_ovf, o_count
  );
endinterface

// File: rtl/qpu_exu_qiu_evtq.sv
// QPU quantum-instruction unit: merges SMIS masks/opcodes into timing-point events,
// timestamps them and buffers them in a small FIFO ahead of the timing-control queue.
module qpu_exu_qiu_evtq #(
  parameter int QUBIT_NUM = 8,
  parameter int EVT_W     = 7,
  parameter int TIME_W    = 24,
  parameter int IMM_W     = 32,
  parameter int DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qpu_exu_qiu_evtq_if.slave     bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ED_W    = QUBIT_NUM * EVT_W;
  localparam int EDATA_W = ED_W + QUBIT_NUM;

  logic [QUBIT_NUM:0]   fifo_op [DEPTH];
  logic [EDATA_W-1:0]   fifo_ed [DEPTH];
  logic [TIME_W-1:0]    fifo_t  [DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;

  logic [QUBIT_NUM-1:0] hold_op, hold_mm;
  logic [ED_W-1:0]      hold_ed;
  logic [TIME_W-1:0]    time_base;
  logic                 ovf;

  logic                 full, empty, accept, pop, keep;
  logic [QUBIT_NUM-1:0] new_op, new_mm;
  logic [ED_W-1:0]      new_ed;
  logic                 new_mbit;
  logic [TIME_W-1:0]    base, new_t;
  logic [IMM_W:0]       sum;
  logic                 sat;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign accept = bus.i_valid & ~full;
  assign pop    = bus.o_ready & ~empty;
  assign keep   = ~bus.i_ntp;

  // Event build: new instruction contents OR'd with the current timing point unless a new point starts.
  always_comb begin
    new_op   = '0;
    new_ed   = '0;
    new_mm   = '0;
    new_mbit = 1'b0;
    if (!bus.i_measure) begin
      for (int q = 0; q < QUBIT_NUM; q++) begin
        new_op[q] = bus.i_rs1[q] | bus.i_rs2[q] | (hold_op[q] & keep);
        new_ed[q*EVT_W +: EVT_W] = (bus.i_rs1[q] ? bus.i_op1 : '0)
                                 | (bus.i_rs2[q] ? bus.i_op2 : '0)
                                 | (keep ? hold_ed[q*EVT_W +: EVT_W] : '0);
      end
      new_mm   = keep ? hold_mm : '0;
      new_mbit = |new_mm;
    end else begin
      new_op   = keep ? hold_op : '0;
      new_ed   = keep ? hold_ed : '0;
      new_mm   = bus.i_rs1 | (keep ? hold_mm : '0);
      new_mbit = 1'b1;
    end
  end

  // Carry into bits at or above TIME_W means the timestamp no longer fits and is clamped.
  always_comb begin
    base  = bus.i_tsync ? bus.i_tbase : time_base;
    sum   = {1'b0, IMM_W'(base)} + {1'b0, bus.i_imm};
    sat   = |sum[IMM_W:TIME_W];
    new_t = sat ? '1 : sum[TIME_W-1:0];
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_op   <= '0;
      hold_ed   <= '0;
      hold_mm   <= '0;
      time_base <= '0;
      ovf       <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr    <= wr_ptr + 1'b1;
        hold_op   <= new_op;
        hold_ed   <= new_ed;
        hold_mm   <= new_mm;
        time_base <= new_t;
      end else if (bus.i_tsync) begin
        time_base <= bus.i_tbase;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      count <= count + 1'b1;
      else if (pop && !accept) count <= count - 1'b1;
      if (accept && sat)       ovf <= 1'b1;
      else if (bus.i_ovf_clr)  ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_op[wr_ptr] <= {new_mbit, new_op};
      fifo_ed[wr_ptr] <= {new_mm, new_ed};
      fifo_t[wr_ptr]  <= new_t;
    end
  end

  assign bus.i_ready  = ~full;
  assign bus.o_valid  = ~empty;
  assign bus.o_oprand = empty ? '0 : fifo_op[rd_ptr];
  assign bus.o_edata  = empty ? '0 : fifo_ed[rd_ptr];
  assign bus.o_tdata  = empty ? '0 : fifo_t[rd_ptr];
  assign bus.o_ovf    = ovf;
  assign bus.o_count  = count;
endmodule

// File: doc/qpu_exu_qiu_evtq.md
Name: qpu_exu_qiu_evtq

Overview:
- Parametrised successor to the QPU quantum-instruction unit.
- Builds per-qubit gate events and measure events from SMIS masks and opcodes.
- Holds the current timing-point event state internally, so no regfile round-trip is needed.
- Computes absolute timestamps with its own adder and buffers results in a DEPTH-entry FIFO in front of the timing-control queue.

Parameters:
- QUBIT_NUM, 8, qubits (gate-event slots); equals the measure mask width.
- EVT_W, 7, opcode/gate-event width per qubit.
- TIME_W, 24, timestamp width.
- IMM_W, 32, immediate (timing offset) width; must be ≥ TIME_W.
- DEPTH, 4, output FIFO entries; power of 2, ≥ 2.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous, active-high reset (asserted = 1). The port keeps the QPU-wide name.
- i_valid, in, 1: instruction valid.
- i_ready, out, 1: instruction accepted when i_valid & i_ready.
- i_rs1, in, QUBIT_NUM: qubit mask 1.
- i_rs2, in, QUBIT_NUM: qubit mask 2.
- i_op1, in, EVT_W: opcode for i_rs1 qubits.
- i_op2, in, EVT_W: opcode for i_rs2 qubits.
- i_imm, in, IMM_W: timing offset (unsigned).
- i_measure, in, 1: instruction is a measure.
- i_ntp, in, 1: instruction starts a new timing point.
- i_tsync, in, 1: load the time base.
- i_tbase, in, TIME_W: time base value loaded by i_tsync.
- o_valid, out, 1: FIFO head valid.
- o_ready, in, 1: downstream accepts head.
- o_oprand, out, QUBIT_NUM+1: bits [QUBIT_NUM-1:0] are gate events; bit [QUBIT_NUM] is the measure event.
- o_edata, out, QUBIT_NUM*EVT_W+QUBIT_NUM: per-qubit opcodes; top QUBIT_NUM bits are the measure mask.
- o_tdata, out, TIME_W: event timestamp.
- o_ovf, out, 1: sticky timestamp overflow.
- i_ovf_clr, in, 1: clears o_ovf.
- o_count, out, clog2(DEPTH)+1: FIFO occupancy.

Behaviour:
- Reset (async, level): FIFO empty, rd/wr pointers 0, o_valid=0, o_count=0, o_ovf=0, time_base=0, hold_op=0, hold_ed=0, hold_mm=0. i_ready=1 one cycle after reset deasserts. Outputs o_oprand/o_edata/o_tdata read 0 while empty.
- i_ready = ~full (registered-state only; no combinational path from o_ready). Push is refused when full even if a pop occurs the same cycle.
- Event build on accept. keep = ~i_ntp.
  - Gate (i_measure=0), per qubit q:
    - op[q] = rs1[q] | rs2[q] | (hold_op[q] & keep).
    - ed[q] = (rs1[q] ? op1 : 0) | (rs2[q] ? op2 : 0) | (keep ? hold_ed[q] : 0).
    - Measure bit = hold_mm!=0 & keep; mask = hold_mm & keep.
  - Measure (i_measure=1):
    - Gate slots = keep ? hold : 0.
    - Measure bit = 1; mask = i_rs1 | (keep ? hold_mm : 0).
  - A qubit in both rs1 and rs2 gets OR of opcodes. This is illegal upstream; the unit does not check it.
- Hold update: on every accept, hold_op/hold_ed/hold_mm take the built event. The event is pushed with the merged contents, so the last push of a timing point carries the full point.
- Timestamp: base = i_tsync ? i_tbase : time_base; sum = base + i_imm, computed at IMM_W+1 bits.
  - If sum ≥ 2^TIME_W: o_tdata = all-ones (saturate), o_ovf set.
  - On accept, time_base ← pushed o_tdata.
  - i_tsync without accept: time_base ← i_tbase.
  - o_ovf: set has priority over i_ovf_clr in the same cycle.
- FIFO: write at wr_ptr on accept, read at rd_ptr on o_valid&o_ready, pointers wrap mod DEPTH, push and pop in the same cycle keep the count. Latency is 1 cycle: accepted at edge N, visible at o_* after edge N when previously empty. No bypass.
- Reset mid-operation: all entries discarded, hold/time state cleared, no partial output.

Test Plan:
- Reset, then gate rs1=0x05, op1=0x11, ntp=1, imm=10, tbase 0 → next cycle o_valid=1, o_oprand=0x005, slots 0,2=0x11, o_tdata=10.
- Then gate rs2=0x02, op2=0x22, ntp=0, imm=0 → o_oprand=0x007, slot1=0x22, slots 0,2 still 0x11, o_tdata=10. Then ntp=1 rs1=0x08 → only bit3 set.
- Measure rs1=0x81, ntp=0 after the gate on 0x01 → o_oprand bit8=1, gate bit0 kept, mask=0x81. Measure ntp=1 → gate slots 0.
- tsync tbase=0xFFFFF0, same-cycle accept imm=0x20 → o_tdata=0xFFFFFF, o_ovf=1. Then i_ovf_clr → o_ovf=0.
- o_ready=0, push 4 → i_ready=0, o_count=4, 5th held. Raise o_ready → FIFO order preserved, pointer wrap verified over 10 pushes.
- Assert rst_n mid-burst with count=3 → o_valid=0, o_count=0 immediately. Next accept uses time_base=0.
